// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset / lock sequencer running on the crystal reference clock.
//
// Pulses the PLL reset, waits for LOCK with a timeout, requires LOCK to stay
// stable for a hold window, then releases the system reset for logic clocked
// by the PLL output. A lock loss while running restarts the sequence.
// A dead PLL ends in a terminal FAIL state that only rst_n clears.
//
// Optional feature macro: PLL_RST_SEQ_RETRY_EN
//   defined   : each lock timeout re-pulses the PLL reset until MAX_RETRY
//               timeouts have been seen, then FAIL.
//   undefined : the first lock timeout goes straight to FAIL; no retry
//               counter is built and retry_cnt_o reads 0.
//
// Ports
//   clkin        in   crystal reference clock (the only clock used here)
//   rst_n        in   asynchronous active-low reset, deasserted synchronously
//   lock_i       in   PLL LOCK, asynchronous to clkin
//   pll_rst_o    out  PLL RESET, active-high
//   sys_rst_n_o  out  active-low reset for the PLL-clocked domain
//   locked_o     out  high only while running with a stable lock
//   fail_o       out  high only in the terminal FAIL state
//   retry_cnt_o  out  lock timeouts since the last RUN entry or reset
//
// States
//   state       | meaning
//   ------------+-------------------------------------------------------
//   PLL_RST     | PLL reset held high for RST_PULSE cycles
//   WAIT_LOCK   | waiting for synchronized LOCK, timeout after LOCK_WAIT
//   STABLE      | LOCK must stay high for HOLD_CYCLES consecutive cycles
//   RUN         | system reset released, locked_o high
//   FAIL        | terminal until rst_n, LOCK ignored

module pll_rst_seq #(
    parameter int unsigned RST_PULSE   = 16,
    parameter int unsigned LOCK_WAIT   = 27000,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       lock_i,
    output logic       pll_rst_o,
    output logic       sys_rst_n_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [2:0] retry_cnt_o
);

    // Each timer is a down-counter loaded with (period - 1); the state moves on
    // when the counter is already at its terminal count of zero, so a state
    // lasts exactly "period" cycles. Counters only decrement while non-zero,
    // so they saturate rather than wrap.
    localparam int unsigned RST_W  = (RST_PULSE   > 1) ? $clog2(RST_PULSE)   : 1;
    localparam int unsigned LOCK_W = (LOCK_WAIT   > 1) ? $clog2(LOCK_WAIT)   : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RST_PULSE - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_WAIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic lock_meta;
    logic lock_s;

    logic [RST_W-1:0]  rst_tmr_q;
    logic [RST_W-1:0]  rst_tmr_d;
    logic [LOCK_W-1:0] lock_tmr_q;
    logic [LOCK_W-1:0] lock_tmr_d;
    logic [HOLD_W-1:0] hold_tmr_q;
    logic [HOLD_W-1:0] hold_tmr_d;

`ifdef PLL_RST_SEQ_RETRY_EN
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    logic [2:0] retry_q;
    logic [2:0] retry_d;
    logic [2:0] retry_inc;

    // Saturating increment; with MAX_RETRY <= 7 the FAIL decision is always
    // taken before the count could reach its ceiling.
    assign retry_inc = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
`endif

    // Two-flop synchronizer: only lock_s is used past this point.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= lock_i;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PLL_RST;
            // The reset pulse timer starts full so that pll_rst_o stays high
            // for RST_PULSE cycles after rst_n is released.
            rst_tmr_q  <= RST_LOAD;
            lock_tmr_q <= '0;
            hold_tmr_q <= '0;
        end else begin
            state_q    <= state_d;
            rst_tmr_q  <= rst_tmr_d;
            lock_tmr_q <= lock_tmr_d;
            hold_tmr_q <= hold_tmr_d;
        end
    end

`ifdef PLL_RST_SEQ_RETRY_EN
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 3'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        rst_tmr_d  = rst_tmr_q;
        lock_tmr_d = lock_tmr_q;
        hold_tmr_d = hold_tmr_q;
`ifdef PLL_RST_SEQ_RETRY_EN
        retry_d    = retry_q;
`endif

        unique case (state_q)
            S_PLL_RST: begin
                if (rst_tmr_q == '0) begin
                    state_d    = S_WAIT_LOCK;
                    lock_tmr_d = LOCK_LOAD;
                end else begin
                    rst_tmr_d = rst_tmr_q - 1'b1;
                end
            end

            S_WAIT_LOCK: begin
                // Lock is tested first so that a lock arriving in the same
                // cycle as the timeout wins.
                if (lock_s) begin
                    state_d    = S_STABLE;
                    hold_tmr_d = HOLD_LOAD;
                end else if (lock_tmr_q == '0) begin
`ifdef PLL_RST_SEQ_RETRY_EN
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_LIMIT) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d   = S_PLL_RST;
                        rst_tmr_d = RST_LOAD;
                    end
`else
                    state_d = S_FAIL;
`endif
                end else begin
                    lock_tmr_d = lock_tmr_q - 1'b1;
                end
            end

            S_STABLE: begin
                // A lock drop restarts the wait without counting a retry.
                if (!lock_s) begin
                    state_d    = S_WAIT_LOCK;
                    lock_tmr_d = LOCK_LOAD;
                end else if (hold_tmr_q == '0) begin
                    state_d = S_RUN;
`ifdef PLL_RST_SEQ_RETRY_EN
                    retry_d = 3'd0;
`endif
                end else begin
                    hold_tmr_d = hold_tmr_q - 1'b1;
                end
            end

            S_RUN: begin
                if (!lock_s) begin
                    state_d   = S_PLL_RST;
                    rst_tmr_d = RST_LOAD;
                end
            end

            S_FAIL: begin
                state_d = S_FAIL;
            end

            default: begin
                state_d   = S_PLL_RST;
                rst_tmr_d = RST_LOAD;
            end
        endcase
    end

    // Outputs are registered and decoded from the next state so they change
    // on the same edge as the state register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_o   <= 1'b1;
            sys_rst_n_o <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            pll_rst_o   <= (state_d == S_PLL_RST);
            sys_rst_n_o <= (state_d == S_RUN);
            locked_o    <= (state_d == S_RUN);
            fail_o      <= (state_d == S_FAIL);
        end
    end

`ifdef PLL_RST_SEQ_RETRY_EN
    assign retry_cnt_o = retry_q;
`else
    assign retry_cnt_o = 3'd0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq with RST_PULSE=4, LOCK_WAIT=64, HOLD_CYCLES=16,
// MAX_RETRY=3. Edge numbers below count clkin rising edges after the most
// recent rst_n release (E1 is the first edge with rst_n high).

module tb_pll_rst_seq;

    localparam int RST_PULSE   = 4;
    localparam int LOCK_WAIT   = 64;
    localparam int HOLD_CYCLES = 16;
    localparam int MAX_RETRY   = 3;

    localparam int PH_PULSE  = 0;
    localparam int PH_ACQ    = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_LIVE   = 3;
    localparam int PH_DEAD   = 4;

    logic       clkin  = 1'b0;
    logic       rst_n  = 1'b0;
    logic       lock_i = 1'b0;
    logic       pll_rst_o;
    logic       sys_rst_n_o;
    logic       locked_o;
    logic       fail_o;
    logic [2:0] retry_cnt_o;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int rel      = 0;
    bit done     = 1'b0;

    // model state
    logic hist [0:255];
    int   m_edge    = 0;
    int   m_phase   = PH_PULSE;
    int   m_elapsed = 0;
    int   m_retries = 0;
    logic m_ls;

    pll_rst_seq #(
        .RST_PULSE  (RST_PULSE),
        .LOCK_WAIT  (LOCK_WAIT),
        .HOLD_CYCLES(HOLD_CYCLES),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .lock_i     (lock_i),
        .pll_rst_o  (pll_rst_o),
        .sys_rst_n_o(sys_rst_n_o),
        .locked_o   (locked_o),
        .fail_o     (fail_o),
        .retry_cnt_o(retry_cnt_o)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt - rel);
        end
    endtask

    // Must be called just after a rising edge.
    task automatic run_to(input int n);
        while (edge_cnt - rel < n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n  = 1'b0;
        lock_i = 1'b0;
        #1;
        chk({tag, "_pll_rst"}, pll_rst_o, 1);
        chk({tag, "_sys_rst_n"}, sys_rst_n_o, 0);
        chk({tag, "_locked"}, locked_o, 0);
        chk({tag, "_fail"}, fail_o, 0);
        chk({tag, "_retry"}, retry_cnt_o, 0);
        repeat (3) @(posedge clkin);
        #1;
        rst_n = 1'b1;
        rel   = edge_cnt;
    endtask

    task automatic run_tests();
        @(posedge clkin);
        #1;

        // normal bring-up, then lock loss while running
        do_reset("por");
        run_to(3);  chk("bring_pll_hi_e3", pll_rst_o, 1);
        run_to(4);  chk("bring_pll_lo_e4", pll_rst_o, 0);
        run_to(14); lock_i = 1'b1;
        run_to(32); chk("bring_sys_lo_e32", sys_rst_n_o, 0);
        run_to(33); chk("bring_sys_hi_e33", sys_rst_n_o, 1);
                    chk("bring_locked_e33", locked_o, 1);
                    chk("bring_retry_e33", retry_cnt_o, 0);
        run_to(40); lock_i = 1'b0;
        run_to(42); chk("loss_sys_hi_e42", sys_rst_n_o, 1);
        run_to(43); chk("loss_sys_lo_e43", sys_rst_n_o, 0);
                    chk("loss_locked_e43", locked_o, 0);
                    chk("loss_pll_hi_e43", pll_rst_o, 1);
        run_to(46); chk("loss_pll_hi_e46", pll_rst_o, 1);
        run_to(47); chk("loss_pll_lo_e47", pll_rst_o, 0);
        run_to(50); lock_i = 1'b1;
        run_to(68); chk("relock_sys_lo_e68", sys_rst_n_o, 0);
        run_to(69); chk("relock_sys_hi_e69", sys_rst_n_o, 1);
                    chk("relock_retry_e69", retry_cnt_o, 0);

        // lock glitch at hold cycle 8
        do_reset("glitch");
        run_to(14); lock_i = 1'b1;
        run_to(25); lock_i = 1'b0;
        run_to(28); lock_i = 1'b1;
        run_to(33); chk("glitch_sys_lo_e33", sys_rst_n_o, 0);
        run_to(46); chk("glitch_sys_lo_e46", sys_rst_n_o, 0);
        run_to(47); chk("glitch_sys_hi_e47", sys_rst_n_o, 1);
                    chk("glitch_retry_e47", retry_cnt_o, 0);

        // reset in WAIT_LOCK cycle 30 restarts the sequence
        do_reset("pre_mid");
        run_to(34);
        do_reset("mid_wait");
        run_to(3);  chk("restart_pll_hi_e3", pll_rst_o, 1);
        run_to(4);  chk("restart_pll_lo_e4", pll_rst_o, 0);

        // dead PLL
        do_reset("dead");
`ifdef PLL_RST_SEQ_RETRY_EN
        run_to(67);  chk("dead_pll_lo_e67", pll_rst_o, 0);
                     chk("dead_retry0_e67", retry_cnt_o, 0);
        run_to(68);  chk("dead_pll_hi_e68", pll_rst_o, 1);
                     chk("dead_retry1_e68", retry_cnt_o, 1);
        run_to(71);  chk("dead_pll_hi_e71", pll_rst_o, 1);
        run_to(72);  chk("dead_pll_lo_e72", pll_rst_o, 0);
        run_to(136); chk("dead_pll_hi_e136", pll_rst_o, 1);
                     chk("dead_retry2_e136", retry_cnt_o, 2);
        run_to(203); chk("dead_fail_lo_e203", fail_o, 0);
        run_to(204); chk("dead_fail_hi_e204", fail_o, 1);
                     chk("dead_retry3_e204", retry_cnt_o, 3);
                     chk("dead_pll_lo_e204", pll_rst_o, 0);
        lock_i = 1'b1;
        run_to(240); chk("dead_fail_hold", fail_o, 1);
                     chk("dead_sys_hold", sys_rst_n_o, 0);
                     chk("dead_pll_hold", pll_rst_o, 0);
`else
        run_to(67);  chk("dead_fail_lo_e67", fail_o, 0);
        run_to(68);  chk("dead_fail_hi_e68", fail_o, 1);
                     chk("dead_pll_lo_e68", pll_rst_o, 0);
                     chk("dead_retry_e68", retry_cnt_o, 0);
        lock_i = 1'b1;
        run_to(100); chk("dead_fail_hold", fail_o, 1);
                     chk("dead_sys_hold", sys_rst_n_o, 0);
                     chk("dead_pll_hold", pll_rst_o, 0);
`endif

        // reset out of FAIL restarts the sequence
        do_reset("from_fail");
        run_to(3);  chk("refail_pll_hi_e3", pll_rst_o, 1);
        run_to(4);  chk("refail_pll_lo_e4", pll_rst_o, 0);
                    chk("refail_fail_e4", fail_o, 0);
        run_to(10);
    endtask

    initial begin
        fork
            begin : edge_counter
                while (!done) begin
                    @(posedge clkin);
                    edge_cnt++;
                end
            end

            // Behavioural model: the FSM sees lock_i as sampled two edges
            // earlier; each phase counts elapsed cycles up to its period.
            begin : model
                while (!done) begin
                    @(posedge clkin or negedge rst_n);
                    if (!rst_n) begin
                        m_edge    = 0;
                        m_phase   = PH_PULSE;
                        m_elapsed = 0;
                        m_retries = 0;
                    end else begin
                        m_edge++;
                        hist[m_edge % 256] = lock_i;
                        m_ls = (m_edge >= 3) ? hist[(m_edge - 2) % 256] : 1'b0;
                        case (m_phase)
                            PH_PULSE: begin
                                m_elapsed++;
                                if (m_elapsed >= RST_PULSE) begin
                                    m_phase   = PH_ACQ;
                                    m_elapsed = 0;
                                end
                            end
                            PH_ACQ: begin
                                if (m_ls) begin
                                    m_phase   = PH_SETTLE;
                                    m_elapsed = 0;
                                end else begin
                                    m_elapsed++;
                                    if (m_elapsed >= LOCK_WAIT) begin
                                        m_elapsed = 0;
`ifdef PLL_RST_SEQ_RETRY_EN
                                        m_retries++;
                                        m_phase = (m_retries == MAX_RETRY) ? PH_DEAD : PH_PULSE;
`else
                                        m_phase = PH_DEAD;
`endif
                                    end
                                end
                            end
                            PH_SETTLE: begin
                                if (!m_ls) begin
                                    m_phase   = PH_ACQ;
                                    m_elapsed = 0;
                                end else begin
                                    m_elapsed++;
                                    if (m_elapsed >= HOLD_CYCLES) begin
                                        m_phase   = PH_LIVE;
                                        m_retries = 0;
                                    end
                                end
                            end
                            PH_LIVE: begin
                                if (!m_ls) begin
                                    m_phase   = PH_PULSE;
                                    m_elapsed = 0;
                                end
                            end
                            default: m_phase = PH_DEAD;
                        endcase
                    end
                end
            end

            begin : compare
                logic [6:0] act;
                logic [6:0] exp;
                while (!done) begin
                    @(negedge clkin);
                    act = {pll_rst_o, sys_rst_n_o, locked_o, fail_o, retry_cnt_o};
                    exp = {m_phase == PH_PULSE, m_phase == PH_LIVE, m_phase == PH_LIVE,
                           m_phase == PH_DEAD, 3'(m_retries)};
                    checks++;
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL model_cmp edge %0d: pll/sys/lck/fail/retry got %b expected %b",
                                 edge_cnt - rel, act, exp);
                    end
                end
            end

            begin : stimulus
                run_tests();
                done = 1'b1;
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
